vga_scan_out: RTL and testbench

//  Downstream display stage for the game-board pixel selector.

---
 rtl/vga_scan_out.sv | 142 ++++++++++++++
 tb/tb_vga_scan_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA timing, pixel address fetch and palette.
// Two-stage pixel pipe: ADDR issued on one tick, RGB/sync/blank one tick later.
module vga_scan_out #(
    parameter int          CLK_DIV   = 2,
    parameter logic [23:0] COLOR0    = 24'h000000,
    parameter logic [23:0] COLOR1    = 24'hFFFFFF,
    parameter logic [23:0] COLOR2    = 24'h202060,
    parameter logic [23:0] COLOR3    = 24'hFFFF00,
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  j,
    output logic [18:0] ADDR,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYN_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYN_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_SYN_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYN_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             vis;
    logic             hs_on;
    logic             vs_on;
    logic [18:0]      addr_next;
    logic             vis_d;
    logic             hs_d;
    logic             vs_d;
    logic [23:0]      color;
    logic [23:0]      rgb_q;

    assign tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider: one tick every CLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Raster position: h wraps each line, v advances on h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Region flags and shift-add pixel index v*640+h for the current position.
    always_comb begin
        vis       = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_on     = (h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END);
        vs_on     = (v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END);
        addr_next = {v_cnt, 9'd0} + {2'd0, v_cnt, 7'd0} + {9'd0, h_cnt};
    end

    // Palette lookup of the colour class returned for the issued ADDR.
    always_comb begin
        color = COLOR0;
        unique case (j)
            2'd0: color = COLOR0;
            2'd1: color = COLOR1;
            2'd2: color = COLOR2;
            2'd3: color = COLOR3;
        endcase
    end

    // Stage 0 issues ADDR and flags; stage 1 emits RGB, sync and blank together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ADDR        <= '0;
            vis_d       <= 1'b0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            rgb_q       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (tick) begin
            ADDR        <= vis ? addr_next : '0;
            vis_d       <= vis;
            hs_d        <= hs_on;
            vs_d        <= vs_on;
            rgb_q       <= vis_d ? color : '0;
            vga_hs      <= ~hs_d;
            vga_vs      <= ~vs_d;
            vga_blank_n <= vis_d;
        end
    end

    // One-clock strobe as the raster leaves the last visible line.
    always_ff @(posedge clk) begin
        if (reset)
            frame_start <= 1'b0;
        else
            frame_start <= tick && (h_cnt == H_LAST) && (v_cnt == V_VIS_LST);
    end

    assign vga_r = rgb_q[23:16];
    assign vga_g = rgb_q[15:8];
    assign vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: directed vectors and edge-timing checks for vga_scan_out.
// u0 default, u1 short vertical frame, u2 CLK_DIV=4.
module tb_vga_scan_out;

    localparam logic [23:0] C0 = 24'h000000;
    localparam logic [23:0] C1 = 24'hFFFFFF;
    localparam logic [23:0] C2 = 24'h202060;
    localparam logic [23:0] C3 = 24'hFFFF00;

    typedef struct {
        int          inst;
        int          c;
        logic [18:0] addr;
        logic [23:0] rgb;
        logic        hs;
        logic        blank;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst0 = 1'b1;

    logic [18:0] addr0, addr1, addr2;
    logic [1:0]  j0, j1, j2;
    logic [7:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic        hs0, vs0, bl0, fs0;
    logic        hs1, vs1, bl1, fs1;
    logic        hs2, vs2, bl2, fs2;

    int cyc = 0;
    int cyc0 = 0;
    int n_cmp = 0;
    int n_bad = 0;

    assign j0 = addr0[1:0];
    assign j1 = addr1[1:0];
    assign j2 = addr2[1:0];

    vga_scan_out u0 (
        .clk(clk), .reset(rst0), .j(j0), .ADDR(addr0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bl0),
        .frame_start(fs0)
    );

    vga_scan_out #(
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u1 (
        .clk(clk), .reset(rst), .j(j1), .ADDR(addr1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bl1),
        .frame_start(fs1)
    );

    vga_scan_out #(.CLK_DIV(4)) u2 (
        .clk(clk), .reset(rst), .j(j2), .ADDR(addr2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bl2),
        .frame_start(fs2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= rst ? 0 : cyc + 1;
        cyc0 <= rst0 ? 0 : cyc0 + 1;
    end

    int f0 [2];
    int nf0 = 0;
    int rise0 = -1;
    logic phs0 = 1'b1;
    int f2 [2];
    int nf2 = 0;
    int rise2 = -1;
    logic phs2 = 1'b1;
    int fs_t [3];
    int fs_n = 0;
    int fs_hi = 0;
    int vf [2];
    int nvf = 0;
    int vrise = -1;
    logic pvs1 = 1'b1;
    int max_a = 0;
    int nz_a = 0;

    always @(negedge clk) begin
        if (!rst0) begin
            if (phs0 && !hs0 && nf0 < 2) begin
                f0[nf0] = cyc0;
                nf0++;
            end
            if (!phs0 && hs0 && rise0 < 0) rise0 = cyc0;
        end
        phs0 = hs0;
        if (!rst) begin
            if (phs2 && !hs2 && nf2 < 2) begin
                f2[nf2] = cyc;
                nf2++;
            end
            if (!phs2 && hs2 && rise2 < 0) rise2 = cyc;
            if (fs1) begin
                fs_hi++;
                if (fs_n < 3) begin
                    fs_t[fs_n] = cyc;
                    fs_n++;
                end
            end
            if (pvs1 && !vs1 && nvf < 2) begin
                vf[nvf] = cyc;
                nvf++;
            end
            if (!pvs1 && vs1 && vrise < 0) vrise = cyc;
            if (cyc >= 1 && cyc < 9600 && int'(addr1) > max_a)
                max_a = int'(addr1);
            if (cyc >= 9600 && cyc <= 19200 && addr1 != 0) nz_a++;
        end
        phs2 = hs2;
        pvs1 = vs1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 200000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < t) chk("wait_cyc timeout", 32'(cyc), 32'(t));
    endtask

    task automatic wait_cyc0(input int t);
        int g = 0;
        while (cyc0 < t && g < 200000) begin
            @(negedge clk);
            g++;
        end
        if (cyc0 < t) chk("wait_cyc0 timeout", 32'(cyc0), 32'(t));
    endtask

    task automatic chk_rst0(input string tag);
        chk({tag, " addr"}, 32'(addr0), 32'd0);
        chk({tag, " rgb"}, 32'({r0, g0, b0}), 32'd0);
        chk({tag, " hs"}, 32'(hs0), 32'd1);
        chk({tag, " vs"}, 32'(vs0), 32'd1);
        chk({tag, " blank_n"}, 32'(bl0), 32'd0);
        chk({tag, " frame_start"}, 32'(fs0), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{0, 1, 19'd0, C0, 1'b1, 1'b0});
        tbl.push_back('{0, 2, 19'd0, C0, 1'b1, 1'b0});
        tbl.push_back('{2, 4, 19'd0, C0, 1'b1, 1'b0});
        tbl.push_back('{0, 4, 19'd1, C0, 1'b1, 1'b1});
        tbl.push_back('{0, 6, 19'd2, C1, 1'b1, 1'b1});
        tbl.push_back('{0, 7, 19'd2, C1, 1'b1, 1'b1});
        tbl.push_back('{0, 8, 19'd3, C2, 1'b1, 1'b1});
        tbl.push_back('{2, 8, 19'd1, C0, 1'b1, 1'b1});
        tbl.push_back('{0, 10, 19'd4, C3, 1'b1, 1'b1});
        tbl.push_back('{2, 11, 19'd1, C0, 1'b1, 1'b1});
        tbl.push_back('{2, 12, 19'd2, C1, 1'b1, 1'b1});
        tbl.push_back('{0, 1280, 19'd639, C2, 1'b1, 1'b1});
        tbl.push_back('{0, 1282, 19'd0, C3, 1'b1, 1'b1});
        tbl.push_back('{0, 1284, 19'd0, C0, 1'b1, 1'b0});
        tbl.push_back('{0, 1314, 19'd0, C0, 1'b1, 1'b0});
        tbl.push_back('{0, 1316, 19'd0, C0, 1'b0, 1'b0});
        tbl.push_back('{0, 1602, 19'd640, C0, 1'b1, 1'b0});
        tbl.push_back('{0, 1604, 19'd641, C0, 1'b1, 1'b1});
        tbl.push_back('{0, 1606, 19'd642, C1, 1'b1, 1'b1});
        tbl.push_back('{2, 2560, 19'd639, C2, 1'b1, 1'b1});
        tbl.push_back('{2, 2632, 19'd0, C0, 1'b0, 1'b0});
        tbl.push_back('{0, 2880, 19'd1279, C2, 1'b1, 1'b1});

        repeat (3) @(negedge clk);
        chk_rst0("reset");
        chk("reset u2 addr", 32'(addr2), 32'd0);
        chk("reset u1 fs", 32'(fs1), 32'd0);
        rst  = 1'b0;
        rst0 = 1'b0;

        foreach (tbl[i]) begin
            wait_cyc(tbl[i].c);
            if (tbl[i].inst == 0) begin
                chk($sformatf("v%0d addr", i), 32'(addr0), 32'(tbl[i].addr));
                chk($sformatf("v%0d rgb", i), 32'({r0, g0, b0}), 32'(tbl[i].rgb));
                chk($sformatf("v%0d hs", i), 32'(hs0), 32'(tbl[i].hs));
                chk($sformatf("v%0d blank", i), 32'(bl0), 32'(tbl[i].blank));
            end else begin
                chk($sformatf("v%0d addr", i), 32'(addr2), 32'(tbl[i].addr));
                chk($sformatf("v%0d rgb", i), 32'({r2, g2, b2}), 32'(tbl[i].rgb));
                chk($sformatf("v%0d hs", i), 32'(hs2), 32'(tbl[i].hs));
                chk($sformatf("v%0d blank", i), 32'(bl2), 32'(tbl[i].blank));
            end
        end

        wait_cyc(3801);
        chk("pre-reset addr", 32'(addr0), 32'd1579);
        chk("pre-reset blank", 32'(bl0), 32'd1);
        rst0 = 1'b1;
        @(negedge clk);
        chk_rst0("mid reset");
        rst0 = 1'b0;
        wait_cyc0(2);
        chk("restart addr c2", 32'(addr0), 32'd0);
        wait_cyc0(4);
        chk("restart addr c4", 32'(addr0), 32'd1);
        chk("restart rgb c4", 32'({r0, g0, b0}), 32'(C0));
        wait_cyc0(6);
        chk("restart rgb c6", 32'({r0, g0, b0}), 32'(C1));
        wait_cyc0(1314);
        chk("restart hs 1314", 32'(hs0), 32'd1);
        wait_cyc0(1316);
        chk("restart hs 1316", 32'(hs0), 32'd0);

        wait_cyc(9280);
        chk("u1 last vis addr", 32'(addr1), 32'd3839);
        wait_cyc(9282);
        chk("u1 last vis blank", 32'(bl1), 32'd1);
        chk("u1 last vis rgb", 32'({r1, g1, b1}), 32'(C3));
        wait_cyc(9284);
        chk("u1 after vis blank", 32'(bl1), 32'd0);
        wait_cyc(9599);
        chk("u1 fs before", 32'(fs1), 32'd0);
        wait_cyc(9600);
        chk("u1 fs pulse", 32'(fs1), 32'd1);
        chk("u1 fs addr", 32'(addr1), 32'd0);
        chk("u1 fs blank", 32'(bl1), 32'd0);
        wait_cyc(9601);
        chk("u1 fs after", 32'(fs1), 32'd0);

        wait_cyc(50000);
        chk("u0 hs first fall", 32'(f0[0]), 32'd1316);
        chk("u0 hs period", 32'(f0[1] - f0[0]), 32'd1600);
        chk("u0 hs low", 32'(rise0 - f0[0]), 32'd192);
        chk("u2 hs first fall", 32'(f2[0]), 32'd2632);
        chk("u2 hs period", 32'(f2[1] - f2[0]), 32'd3200);
        chk("u2 hs low", 32'(rise2 - f2[0]), 32'd384);
        chk("u1 fs count", 32'(fs_n), 32'd3);
        chk("u1 fs high clks", 32'(fs_hi), 32'd3);
        chk("u1 fs t0", 32'(fs_t[0]), 32'd9600);
        chk("u1 fs t1", 32'(fs_t[1]), 32'd28800);
        chk("u1 fs t2", 32'(fs_t[2]), 32'd48000);
        chk("u1 vs first fall", 32'(vf[0]), 32'd12804);
        chk("u1 vs period", 32'(vf[1] - vf[0]), 32'd19200);
        chk("u1 vs low", 32'(vrise - vf[0]), 32'd3200);
        chk("u1 max addr", 32'(max_a), 32'd3839);
        chk("u1 blank-rows addr", 32'(nz_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
